// File: rtl/packed_sample_framer.sv
// Packs 16-bit real/imag sign-bit words into a 32-bit AXI-Stream through a small FIFO.
// Frames of FRAME_WORDS words get tlast; FIFO-full drops are counted and flagged.
module packed_sample_framer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_WORDS = 256,
    parameter int CNT_W       = 16
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          enable,
    input  logic                          s_tvalid,
    input  logic [15:0]                   s_real,
    input  logic [15:0]                   s_imag,
    output logic [31:0]                   m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              drop_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int DW = 33;

    logic [DW-1:0]    mem_q [FIFO_DEPTH];
    logic [DW-1:0]    mem_d [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]    wr_idx_q, wr_idx_d;
    logic             active_q, active_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;
    logic             overflow_q, overflow_d;

    logic [AW:0]      level;
    logic             full;
    logic             active_next;
    logic             wr_en;
    logic             drop;
    logic             rd_en;
    logic             word_last;

    // Next-state logic: framing, write/drop decision, pointer and counter updates.
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_idx_d     = wr_idx_q;
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;

        level       = wr_ptr_q - rd_ptr_q;
        full        = (level == (AW+1)'(FIFO_DEPTH));
        // Enable only takes effect between frames, so a started frame always completes.
        active_next = (wr_idx_q == '0) ? enable : active_q;
        active_d    = active_next;
        wr_en       = s_tvalid & active_next & ~full;
        drop        = s_tvalid & active_next & full;
        rd_en       = (level != '0) & m_tready;
        word_last   = (wr_idx_q == IW'(FRAME_WORDS - 1));

        if (wr_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = {s_imag, s_real, word_last};
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
            wr_idx_d                = word_last ? '0 : wr_idx_q + IW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        // A dropped word leaves wr_idx alone so tlast stays aligned to stored words.
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != {CNT_W{1'b1}}) begin
                drop_count_d = drop_count_q + CNT_W'(1);
            end else begin
                drop_count_d = drop_count_q;
            end
        end else begin
            overflow_d = overflow_q;
        end

        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State registers with asynchronous reset, including FIFO storage.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wr_idx_q     <= '0;
            active_q     <= 1'b0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_idx_q     <= wr_idx_d;
            active_q     <= active_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign m_tdata    = mem_q[rd_ptr_q[AW-1:0]][DW-1:1];
    assign m_tlast    = mem_q[rd_ptr_q[AW-1:0]][0];
    assign m_tvalid   = (wr_ptr_q != rd_ptr_q);
    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_packed_sample_framer.sv
// Self-checking bench for packed_sample_framer: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_packed_sample_framer;

    localparam int DEPTH = 16;
    localparam int FW    = 4;
    localparam int CW    = 4;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        enable = 1'b0;
    logic        s_tvalid = 1'b0;
    logic [15:0] s_real = 16'h0;
    logic [15:0] s_imag = 16'h0;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic [4:0]  fifo_level;
    logic [3:0]  drop_count;
    logic        overflow;

    packed_sample_framer #(.FIFO_DEPTH(DEPTH), .FRAME_WORDS(FW), .CNT_W(CW)) dut (
        .aclk(clk), .areset(areset), .enable(enable), .s_tvalid(s_tvalid),
        .s_real(s_real), .s_imag(s_imag), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .fifo_level(fifo_level),
        .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int last_cnt = 0;

    // Reference model: a queue of {data,last}, frame position, frame-open flag, drops.
    logic [32:0] mq[$];
    int          m_pos = 0;
    bit          m_open = 1'b0;
    int          m_drops = 0;
    bit          m_ovf = 1'b0;

    bit          stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    typedef struct {
        bit          tv;
        logic [15:0] re;
        logic [15:0] im;
        bit          rdy;
        bit          ev;
        logic [31:0] ed;
        bit          el;
        logic [4:0]  elev;
    } vec_t;
    vec_t vec[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_pos = 0;
        m_open = 1'b0;
        m_drops = 0;
        m_ovf = 1'b0;
        stall_prev = 1'b0;
    endtask

    task automatic model_step(input bit tv, input logic [15:0] re, input logic [15:0] im,
                              input bit en, input bit rdy);
        bit accepting;
        bit pop;
        accepting = (m_pos == 0) ? en : m_open;
        pop = (mq.size() != 0) && rdy;
        if (tv && accepting) begin
            if (mq.size() == DEPTH) begin
                if (m_drops < 15) m_drops++;
                m_ovf = 1'b1;
            end else begin
                mq.push_back({im, re, (m_pos == FW - 1)});
                m_pos = (m_pos + 1) % FW;
            end
        end
        m_open = accepting;
        if (pop) void'(mq.pop_front());
    endtask

    // One clock: drive inputs, observe pre-edge handshake, advance model, compare after edge.
    task automatic cycle(input bit tv, input logic [15:0] re, input logic [15:0] im,
                         input bit en, input bit rdy);
        s_tvalid = tv; s_real = re; s_imag = im; enable = en; m_tready = rdy;
        #1;
        if (stall_prev) begin
            chk("hold_valid", 64'(m_tvalid), 64'd1);
            chk("hold_data", 64'(m_tdata), 64'(prev_data));
            chk("hold_last", 64'(m_tlast), 64'(prev_last));
        end
        stall_prev = m_tvalid && !m_tready;
        prev_data = m_tdata;
        prev_last = m_tlast;
        if (m_tvalid && m_tready) begin
            hs_cnt++;
            if (m_tlast) last_cnt++;
        end
        model_step(tv, re, im, en, rdy);
        @(negedge clk);
        chk("tvalid", 64'(m_tvalid), 64'(mq.size() != 0));
        chk("level", 64'(fifo_level), 64'(mq.size()));
        chk("drops", 64'(drop_count), 64'(m_drops));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (mq.size() != 0) begin
            chk("tdata", 64'(m_tdata), 64'(mq[0][32:1]));
            chk("tlast", 64'(m_tlast), 64'(mq[0][0]));
        end
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0; m_tready = 1'b0; enable = 1'b0;
        areset = 1'b1;
        model_clear();
        #1;
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_tdata), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_drops", 64'(drop_count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        areset = 1'b0;
    endtask

    initial begin
        int hs0;
        int l0;
        for (int k = 1; k <= 8; k++) begin
            vec[k-1] = '{1'b1, 16'(k), 16'h8000 | 16'(k), 1'b1, 1'b1,
                         {16'h8000 | 16'(k), 16'(k)}, (k % 4 == 0), 5'd1};
        end
        vec[8] = '{1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0};

        @(negedge clk);
        do_reset();

        // Test 1: streaming with one-cycle latency.
        for (int i = 0; i < 9; i++) begin
            cycle(vec[i].tv, vec[i].re, vec[i].im, 1'b1, vec[i].rdy);
            chk("t1_valid", 64'(m_tvalid), 64'(vec[i].ev));
            chk("t1_level", 64'(fifo_level), 64'(vec[i].elev));
            if (vec[i].ev) begin
                chk("t1_data", 64'(m_tdata), 64'(vec[i].ed));
                chk("t1_last", 64'(m_tlast), 64'(vec[i].el));
            end
        end

        // Test 2: fill past full, then drain.
        for (int k = 1; k <= 20; k++) cycle(1'b1, 16'(k), 16'h8000 | 16'(k), 1'b1, 1'b0);
        chk("t2_level", 64'(fifo_level), 64'd16);
        chk("t2_drops", 64'(drop_count), 64'd4);
        chk("t2_ovf", 64'(overflow), 64'd1);
        hs0 = hs_cnt; l0 = last_cnt;
        for (int k = 0; k < 17; k++) cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
        chk("t2_drained", 64'(hs_cnt - hs0), 64'd16);
        chk("t2_lasts", 64'(last_cnt - l0), 64'd4);

        // Test 3: enable drops mid-frame; frame still completes.
        hs0 = hs_cnt; l0 = last_cnt;
        for (int k = 1; k <= 8; k++)
            cycle(1'b1, 16'(16'h30 + k), 16'(16'h0300 + k), (k <= 2), 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("t3_words", 64'(hs_cnt - hs0), 64'd4);
        chk("t3_lasts", 64'(last_cnt - l0), 64'd1);
        chk("t3_drops", 64'(drop_count), 64'd4);

        // Test 4: random backpressure over a 12-word stream.
        hs0 = hs_cnt; l0 = last_cnt;
        for (int k = 1; k <= 12; k++)
            cycle(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'($urandom_range(0, 1)));
        for (int k = 0; k < 100 && mq.size() != 0; k++)
            cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'($urandom_range(0, 1)));
        chk("t4_words", 64'(hs_cnt - hs0), 64'd12);
        chk("t4_lasts", 64'(last_cnt - l0), 64'd3);

        // Test 5: reset mid-frame, then a fresh frame.
        cycle(1'b1, 16'h0051, 16'h0501, 1'b1, 1'b0);
        cycle(1'b1, 16'h0052, 16'h0502, 1'b1, 1'b0);
        do_reset();
        hs0 = hs_cnt; l0 = last_cnt;
        for (int k = 1; k <= 4; k++) cycle(1'b1, 16'(16'h60 + k), 16'(16'h0600 + k), 1'b1, 1'b1);
        cycle(1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
        chk("t5_words", 64'(hs_cnt - hs0), 64'd4);
        chk("t5_lasts", 64'(last_cnt - l0), 64'd1);

        // Test 6: drop counter saturation.
        for (int k = 1; k <= 40; k++) cycle(1'b1, 16'(k), 16'(k), 1'b1, 1'b0);
        chk("t6_drops", 64'(drop_count), 64'hF);
        chk("t6_ovf", 64'(overflow), 64'd1);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++)
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        chk("rand_ovf", 64'(overflow), 64'd1);

        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
